// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one stack RAM and its stack pointer between two requesters
// (0: core datapath, 1: call/irq unit) with round-robin arbitration.
//
// Operations are sequenced against a synchronous RAM with 1-cycle read latency:
//   grant (IDLE) -> PUSH -> IDLE
//   grant (IDLE) -> POP_RD -> POP_DATA -> IDLE (rvalid pulses in this IDLE cycle)
//
// Parameters
//   BITS        data word width
//   DEPTH_BITS  RAM address width, depth = 2**DEPTH_BITS
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid/op/wdata          request (op 1 = push, 0 = pop), held until reqN_ready
//   reqN_ready                   1-cycle accept pulse
//   reqN_rvalid                  1-cycle pop-result pulse, rdata valid alongside
//   rdata                        shared pop result
//   mem_we/mem_addr/mem_wdata    RAM write strobe, address, write data
//   mem_rdata                    RAM read data, valid 1 cycle after mem_addr
//   sp, full, empty              fill level and its flags
//   err, err_clr                 sticky overflow/underflow flag and its clear
//
// Optional feature (macro STACK_WATERMARK_EN): adds output high_water, the largest
// fill level seen since reset or the last err_clr.

module stack_arbiter #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_op,
  input  logic [BITS-1:0]       req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  input  logic                  req1_valid,
  input  logic                  req1_op,
  input  logic [BITS-1:0]       req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [BITS-1:0]       rdata,
  output logic                  mem_we,
  output logic [DEPTH_BITS-1:0] mem_addr,
  output logic [BITS-1:0]       mem_wdata,
  input  logic [BITS-1:0]       mem_rdata,
  output logic [DEPTH_BITS:0]   sp,
  output logic                  full,
  output logic                  empty,
  output logic                  err,
  input  logic                  err_clr
`ifdef STACK_WATERMARK_EN
  ,
  output logic [DEPTH_BITS:0]   high_water
`endif
);

  localparam logic [DEPTH_BITS:0] SpFull = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0] SpOne  = {{DEPTH_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StPush, StPopRd, StPopData} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_BITS:0]   sp_q, sp_d;
  logic                  err_q, err_d;
  logic                  last_q, last_d;     // requester granted most recently
  logic                  gnt_q, gnt_d;       // owner of the operation in flight
  logic [BITS-1:0]       data_q, data_d;     // latched push data
  logic                  uflow_q, uflow_d;   // current pop hit an empty stack
  logic [BITS-1:0]       rdata_q, rdata_d;
  logic [1:0]            rvalid_q, rvalid_d;
  // mem_addr/mem_wdata hold their last driven value when not actively used
  logic [DEPTH_BITS-1:0] addr_q;
  logic [BITS-1:0]       wdata_q;

  logic                  gnt_any;
  logic                  win;
  logic                  win_op;
  logic [BITS-1:0]       win_wdata;
  logic [DEPTH_BITS:0]   sp_dec;
  logic                  err_evt;

  // Arbitration: on contention the requester not granted last time wins.
  always_comb begin
    gnt_any   = req0_valid | req1_valid;
    win       = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    win_op    = win ? req1_op : req0_op;
    win_wdata = win ? req1_wdata : req0_wdata;
  end

  assign sp_dec = sp_q - SpOne;
  assign full   = (sp_q == SpFull);
  assign empty  = (sp_q == '0);

  // State register (FSM plus datapath registers).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sp_q     <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      data_q   <= '0;
      uflow_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      err_q    <= err_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      uflow_q  <= uflow_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      addr_q   <= mem_addr;
      wdata_q  <= mem_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (gnt_any) state_d = win_op ? StPush : StPopRd;
      StPush:    state_d = StIdle;
      StPopRd:   state_d = StPopData;
      StPopData: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath next-state logic.
  always_comb begin
    sp_d     = sp_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    data_d   = data_q;
    uflow_d  = uflow_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    err_evt  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          last_d = win;
          gnt_d  = win;
          data_d = win_wdata;
        end
      end
      StPush: begin
        // Overflow push was already accepted; it is dropped here.
        if (!full) sp_d = sp_q + SpOne;
        else       err_evt = 1'b1;
      end
      StPopRd: begin
        if (!empty) begin
          sp_d    = sp_dec;
          uflow_d = 1'b0;
        end else begin
          uflow_d = 1'b1;
          err_evt = 1'b1;
        end
      end
      StPopData: begin
        rdata_d  = uflow_q ? '0 : mem_rdata;
        rvalid_d = gnt_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
    // A new error in the same cycle as err_clr leaves err set.
    err_d = err_evt | (err_q & ~err_clr);
  end

  // Output logic.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          req0_ready = ~win;
          req1_ready = win;
        end
      end
      StPush: begin
        if (!full) begin
          mem_we    = 1'b1;
          mem_addr  = sp_q[DEPTH_BITS-1:0];
          mem_wdata = data_q;
        end
      end
      StPopRd: begin
        if (!empty) mem_addr = sp_dec[DEPTH_BITS-1:0];
      end
      default: ;
    endcase
  end

  assign req0_rvalid = rvalid_q[0];
  assign req1_rvalid = rvalid_q[1];
  assign rdata       = rdata_q;
  assign sp          = sp_q;
  assign err         = err_q;

`ifdef STACK_WATERMARK_EN
  logic [DEPTH_BITS:0] hw_q, hw_d;

  always_comb begin
    if (err_clr)          hw_d = sp_q;
    else if (sp_q > hw_q) hw_d = sp_q;
    else                  hw_d = hw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hw_q <= '0;
    else        hw_q <= hw_d;
  end

  assign high_water = hw_q;
`endif

endmodule
